id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the CPU pipeline. Captures the decoded instruction fields and the two register-file read operands (Rs_Out/Rt_Out) into the ID/EX pipeline register. Detects load-use hazards and inserts one bubble for each. Holds a multiply in EX for a parameterised number of cycles, and honours branch flush and downstream stall.

## Interface
Parameters:
- MUL_LAT, 3: total cycles a MUL occupies EX; legal range 1..8.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- ID_Valid  in  1  IF/ID holds a real instruction.
- ID_Op  in  4  opcode (encodings in shared package).
- ID_Rd, ID_Rs, ID_Rt  in  6 each  register specifiers; also drive the register file read addresses.
- ID_Imm  in  16  raw immediate.
- Rs_Out, Rt_Out  in  32 each  register file read data.
- Flush  in  1  taken branch resolved in EX; kill ID instruction.
- Stall_Ext  in  1  downstream (MEM) stall; freeze stage.
- IFID_Stall  out  1  combinational; hold PC and IF/ID this cycle.
- EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Last  out  1 each.
- EX_Op  out  4.
- EX_Rd, EX_Rs, EX_Rt  out  6 each.
- EX_A, EX_B, EX_Imm  out  32 each.

## Operation
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, ADDI=5, LW=6, SW=7, BEQ=8, MUL=9; 10..15 decode as NOP.
- Control decode:
  - RegWrite: ADD, SUB, AND, OR, ADDI, LW, MUL.
  - MemRead: LW. MemWrite: SW.
  - Uses Rs: all except NOP. Uses Rt: ADD, SUB, AND, OR, SW, BEQ, MUL.
- Normal capture:
  - EX_A ← Rs_Out, EX_B ← Rt_Out.
  - EX_Imm ← ID_Imm sign-extended to 32 bits.
  - Specifiers and op copied; EX_Valid ← ID_Valid.
  - All control bits forced 0 when ID_Valid=0.
- Load-use hazard: EX_Valid & EX_MemRead & ID_Valid & ((uses Rs & EX_Rd==ID_Rs) | (uses Rt & EX_Rd==ID_Rt)).
  - All 6 bits are compared, including register 0; register 0 is writable in this register file.
  - Response: IFID_Stall=1; a bubble is loaded (EX_Valid, RegWrite, MemRead, MemWrite, EX_Last = 0).
- MUL multi-cycle: 2-state FSM, IDLE/MULBUSY, with a down-counter cnt.
  - When a MUL is captured and MUL_LAT>1: go to MULBUSY with cnt=MUL_LAT-1.
  - In MULBUSY: EX_* hold, IFID_Stall=1, cnt decrements each non-stalled cycle; return to IDLE when cnt reaches 0.
  - EX_Last=1 on the final EX cycle of every valid instruction. For MUL this is the MUL_LAT-th cycle; for all other ops it equals EX_Valid.
- Priority per cycle: RST > Flush > Stall_Ext > MULBUSY > load-use > normal.
  - Flush: load a bubble, FSM → IDLE, cnt=0, IFID_Stall=0.
  - Stall_Ext: all registers, FSM and cnt hold; IFID_Stall=1.

## Timing
- Reset: every output register is 0, FSM=IDLE, cnt=0. IFID_Stall=0 while RST=1.
- Latency: ID fields present in cycle N appear on EX_* after the rising edge ending cycle N (1 cycle).
- The register file writes on the negedge of CLK. A writeback in cycle N is therefore visible on Rs_Out/Rt_Out before the posedge ending cycle N. No WB→ID bypass exists in this block.
- IFID_Stall is combinational from current-cycle inputs and registered state. It must settle before the posedge.
- Load-use costs exactly 1 bubble. In the following cycle EX holds the bubble, the hazard clears, and the ID instruction is captured.
- Flush arriving together with a load-use or MULBUSY condition: Flush wins; no stall is asserted.
- Stall_Ext during MULBUSY: cnt does not decrement.
- RST during MULBUSY: back to reset state on the next edge; the MUL is discarded.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams OP_NOP..OP_MUL;
  - widths REG_AW=6, XLEN=32;
  - the FSM state encoding.
- The decode of RegWrite/MemRead/MemWrite/uses-Rs/uses-Rt goes in a combinational sub-module, id_decode (op in, five flags out). It is reused by the hazard logic.
- Remaining content: the pipeline register, hazard compare, and FSM/counter, all in id_ex_stage.

## Test plan
- ADD x3,x4,x2 with Rs_Out=4, Rt_Out=27 → next cycle EX_Valid=1, EX_A=4, EX_B=27, EX_Rd=3, EX_RegWrite=1, EX_Last=1.
- ADDI x5,x1,0xFFFF with Rs_Out=100 → EX_Imm=0xFFFFFFFF, EX_A=100.
- LW x5 followed by ADD x6,x5,x1 → IFID_Stall=1 for exactly 1 cycle; one bubble (EX_Valid=0); ADD captured the cycle after. Repeat with Rs=10, Rt=11 (no match) → no stall.
- MUL x7,x10,x11 with MUL_LAT=3 → EX holds A=30, B=10 for 3 cycles; IFID_Stall=1 for 2 cycles; EX_Last=1 only in the 3rd cycle. With Stall_Ext=1 for 2 cycles mid-MUL → EX held 5 cycles total.
- Flush asserted in the same cycle as a load-use hazard → bubble loaded, IFID_Stall=0, FSM IDLE.
- RST pulsed during MULBUSY → all outputs 0 next cycle; a following ADD proceeds with 1-cycle latency.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : shared opcodes, datapath widths and ID/EX FSM encoding    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cpu_pkg;
  localparam int REG_AW = 6;
  localparam int XLEN   = 32;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MULBUSY = 1'b1;

  function automatic logic [XLEN-1:0] sign_ext_imm(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction
endpackage
`default_nettype wire

// File: rtl/id_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_decode : opcode to control flags and register-use flags          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module id_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_op,
  output logic       o_reg_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_uses_rs,
  output logic       o_uses_rt
);

  always_comb begin
    o_reg_write = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_uses_rs   = 1'b0;
    o_uses_rt   = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: begin
        o_reg_write = 1'b1;
        o_uses_rs   = 1'b1;
        o_uses_rt   = 1'b1;
      end
      OP_ADDI: begin
        o_reg_write = 1'b1;
        o_uses_rs   = 1'b1;
      end
      OP_LW: begin
        o_reg_write = 1'b1;
        o_mem_read  = 1'b1;
        o_uses_rs   = 1'b1;
      end
      OP_SW: begin
        o_mem_write = 1'b1;
        o_uses_rs   = 1'b1;
        o_uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        o_uses_rs   = 1'b1;
        o_uses_rt   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register, load-use bubble, MUL hold    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ID_Valid,
  input  logic [3:0]        ID_Op,
  input  logic [REG_AW-1:0] ID_Rd,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [15:0]       ID_Imm,
  input  logic [XLEN-1:0]   Rs_Out,
  input  logic [XLEN-1:0]   Rt_Out,
  input  logic              Flush,
  input  logic              Stall_Ext,
  output logic              IFID_Stall,
  output logic              EX_Valid,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_Last,
  output logic [3:0]        EX_Op,
  output logic [REG_AW-1:0] EX_Rd,
  output logic [REG_AW-1:0] EX_Rs,
  output logic [REG_AW-1:0] EX_Rt,
  output logic [XLEN-1:0]   EX_A,
  output logic [XLEN-1:0]   EX_B,
  output logic [XLEN-1:0]   EX_Imm
);

  localparam logic [2:0] c_cnt_init   = 3'(MUL_LAT - 1);
  localparam logic       c_mul_single = (MUL_LAT == 1);

  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_uses_rs;
  logic       w_uses_rt;
  logic       w_load_use;
  logic       w_mul_busy;
  logic       w_start_mul;
  logic [0:0] r_state;
  logic [2:0] r_cnt;

  id_decode u_id_decode (
    .i_op        (ID_Op),
    .o_reg_write (w_reg_write),
    .o_mem_read  (w_mem_read),
    .o_mem_write (w_mem_write),
    .o_uses_rs   (w_uses_rs),
    .o_uses_rt   (w_uses_rt)
  );

  // Register 0 is writable here, so the full specifier is compared.
  assign w_load_use = EX_Valid & EX_MemRead & ID_Valid &
                      ((w_uses_rs & (EX_Rd == ID_Rs)) |
                       (w_uses_rt & (EX_Rd == ID_Rt)));
  assign w_mul_busy  = (r_state == ST_MULBUSY);
  assign w_start_mul = ID_Valid & (ID_Op == OP_MUL) & ~c_mul_single;
  assign IFID_Stall  = ~RST & ~Flush & (Stall_Ext | w_mul_busy | w_load_use);

  always_ff @(posedge CLK) begin
    if (RST) begin
      EX_Valid    <= 1'b0;
      EX_RegWrite <= 1'b0;
      EX_MemRead  <= 1'b0;
      EX_MemWrite <= 1'b0;
      EX_Last     <= 1'b0;
      EX_Op       <= '0;
      EX_Rd       <= '0;
      EX_Rs       <= '0;
      EX_Rt       <= '0;
      EX_A        <= '0;
      EX_B        <= '0;
      EX_Imm      <= '0;
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
    end else if (Flush) begin
      EX_Valid    <= 1'b0;
      EX_RegWrite <= 1'b0;
      EX_MemRead  <= 1'b0;
      EX_MemWrite <= 1'b0;
      EX_Last     <= 1'b0;
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
    end else if (!Stall_Ext) begin
      if (w_mul_busy) begin
        // EX contents hold; only the countdown advances.
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          r_state <= ST_IDLE;
          EX_Last <= 1'b1;
        end
      end else if (w_load_use) begin
        EX_Valid    <= 1'b0;
        EX_RegWrite <= 1'b0;
        EX_MemRead  <= 1'b0;
        EX_MemWrite <= 1'b0;
        EX_Last     <= 1'b0;
      end else begin
        EX_Valid    <= ID_Valid;
        EX_RegWrite <= ID_Valid & w_reg_write;
        EX_MemRead  <= ID_Valid & w_mem_read;
        EX_MemWrite <= ID_Valid & w_mem_write;
        EX_Last     <= ID_Valid & ((ID_Op != OP_MUL) | c_mul_single);
        EX_Op       <= ID_Op;
        EX_Rd       <= ID_Rd;
        EX_Rs       <= ID_Rs;
        EX_Rt       <= ID_Rt;
        EX_A        <= Rs_Out;
        EX_B        <= Rt_Out;
        EX_Imm      <= sign_ext_imm(ID_Imm);
        r_state     <= w_start_mul ? ST_MULBUSY : ST_IDLE;
        r_cnt       <= w_start_mul ? c_cnt_init : 3'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_id_ex_stage : directed stimulus, cycle model and literal checks  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int MUL_LAT = 3;

  logic        CLK, RST, ID_Valid, Flush, Stall_Ext;
  logic [3:0]  ID_Op;
  logic [5:0]  ID_Rd, ID_Rs, ID_Rt;
  logic [15:0] ID_Imm;
  logic [31:0] Rs_Out, Rt_Out;
  logic        IFID_Stall, EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Last;
  logic [3:0]  EX_Op;
  logic [5:0]  EX_Rd, EX_Rs, EX_Rt;
  logic [31:0] EX_A, EX_B, EX_Imm;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RST(RST), .ID_Valid(ID_Valid), .ID_Op(ID_Op),
    .ID_Rd(ID_Rd), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Imm(ID_Imm),
    .Rs_Out(Rs_Out), .Rt_Out(Rt_Out), .Flush(Flush), .Stall_Ext(Stall_Ext),
    .IFID_Stall(IFID_Stall), .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_Last(EX_Last),
    .EX_Op(EX_Op), .EX_Rd(EX_Rd), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
    .EX_A(EX_A), .EX_B(EX_B), .EX_Imm(EX_Imm)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit op_rw(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9};
  endfunction
  function automatic bit op_rs(input logic [3:0] op);
    return op inside {[4'd1:4'd9]};
  endfunction
  function automatic bit op_rt(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9};
  endfunction

  // Model: contents of EX plus how many EX cycles the current instruction still needs.
  bit          m_valid, m_rw, m_mr, m_mw, m_last, m_known;
  logic [3:0]  m_op;
  logic [5:0]  m_rd, m_rs, m_rt;
  logic [31:0] m_a, m_b, m_imm;
  int          m_remain;

  function automatic bit lu_now();
    return m_valid && m_mr && ID_Valid &&
           ((op_rs(ID_Op) && m_rd == ID_Rs) || (op_rt(ID_Op) && m_rd == ID_Rt));
  endfunction

  task automatic m_bubble();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_last = 0; m_remain = 0; m_known = 0;
  endtask

  initial begin
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_last = 0; m_known = 0;
    m_op = 0; m_rd = 0; m_rs = 0; m_rt = 0; m_a = 0; m_b = 0; m_imm = 0; m_remain = 0;
  end

  always @(posedge CLK) begin
    if (RST) begin
      m_bubble();
      m_known = 1; m_op = 0; m_rd = 0; m_rs = 0; m_rt = 0; m_a = 0; m_b = 0; m_imm = 0;
    end else if (Flush) begin
      m_bubble();
    end else if (Stall_Ext) begin
      m_remain = m_remain;
    end else if (m_valid && m_remain > 1) begin
      m_remain = m_remain - 1;
      m_last   = (m_remain == 1);
    end else if (lu_now()) begin
      m_bubble();
    end else begin
      m_valid  = ID_Valid;
      m_rw     = ID_Valid && op_rw(ID_Op);
      m_mr     = ID_Valid && ID_Op == 4'd6;
      m_mw     = ID_Valid && ID_Op == 4'd7;
      m_remain = !ID_Valid ? 0 : (ID_Op == 4'd9 ? MUL_LAT : 1);
      m_last   = (m_remain == 1);
      m_known  = 1;
      m_op = ID_Op; m_rd = ID_Rd; m_rs = ID_Rs; m_rt = ID_Rt;
      m_a = Rs_Out; m_b = Rt_Out;
      m_imm = (ID_Imm >= 16'h8000) ? 32'(ID_Imm) - 32'h10000 : 32'(ID_Imm);
    end
  end

  always @(negedge CLK) begin
    bit exp_stall, mism;
    exp_stall = !RST && !Flush && (Stall_Ext || (m_valid && m_remain > 1) || lu_now());
    mism = (IFID_Stall !== exp_stall) || (EX_Valid !== m_valid) || (EX_RegWrite !== m_rw) ||
           (EX_MemRead !== m_mr) || (EX_MemWrite !== m_mw) || (EX_Last !== m_last);
    if (m_known)
      mism = mism || (EX_Op !== m_op) || (EX_Rd !== m_rd) || (EX_Rs !== m_rs) ||
             (EX_Rt !== m_rt) || (EX_A !== m_a) || (EX_B !== m_b) || (EX_Imm !== m_imm);
    total++;
    if (mism) begin
      bad++;
      $display("FAIL cycle_model t=%0t got/exp: stall=%b/%b v=%b/%b rw=%b/%b mr=%b/%b mw=%b/%b last=%b/%b op=%h/%h rd=%h/%h a=%h/%h b=%h/%h imm=%h/%h",
               $time, IFID_Stall, exp_stall, EX_Valid, m_valid, EX_RegWrite, m_rw,
               EX_MemRead, m_mr, EX_MemWrite, m_mw, EX_Last, m_last, EX_Op, m_op,
               EX_Rd, m_rd, EX_A, m_a, EX_B, m_b, EX_Imm, m_imm);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic id(input int v, input int op, input int rd, input int rs, input int rt,
                    input int imm, input int a, input int b);
    ID_Valid = 1'(v); ID_Op = 4'(op); ID_Rd = 6'(rd); ID_Rs = 6'(rs); ID_Rt = 6'(rt);
    ID_Imm = 16'(imm); Rs_Out = 32'(a); Rt_Out = 32'(b);
  endtask

  initial begin
    RST = 1; Flush = 0; Stall_Ext = 1;
    id(1, 6, 5, 1, 2, 0, 0, 0);
    cyc(); cyc(); #1;
    chk("rst_stall", 32'(IFID_Stall), 0);
    chk("rst_valid", 32'(EX_Valid), 0);
    chk("rst_a", EX_A, 0);
    chk("rst_imm", EX_Imm, 0);
    RST = 0; Stall_Ext = 0;

    // ADD x3,x4,x2
    id(1, 1, 3, 4, 2, 0, 4, 27); cyc();
    chk("add_valid", 32'(EX_Valid), 1); chk("add_a", EX_A, 4); chk("add_b", EX_B, 27);
    chk("add_rd", 32'(EX_Rd), 3); chk("add_rw", 32'(EX_RegWrite), 1); chk("add_last", 32'(EX_Last), 1);

    // ADDI sign extension, negative and positive
    id(1, 5, 5, 1, 0, 16'hFFFF, 100, 0); cyc();
    chk("addi_imm", EX_Imm, 32'hFFFF_FFFF); chk("addi_a", EX_A, 100);
    id(1, 5, 5, 1, 0, 16'h7FFF, 1, 0); cyc();
    chk("addi_imm_pos", EX_Imm, 32'h0000_7FFF);

    // LW x5 then ADD x6,x5,x1: one bubble
    id(1, 6, 5, 1, 0, 4, 0, 0); cyc();
    id(1, 1, 6, 5, 1, 0, 7, 8); #1;
    chk("lu_stall", 32'(IFID_Stall), 1);
    cyc();
    chk("lu_bubble", 32'(EX_Valid), 0); #1;
    chk("lu_clear", 32'(IFID_Stall), 0);
    cyc();
    chk("lu_add_rd", 32'(EX_Rd), 6); chk("lu_add_a", EX_A, 7);

    // no match, and ADDI whose Rt field matches but is unused
    id(1, 6, 5, 1, 0, 0, 0, 0); cyc();
    id(1, 1, 6, 10, 11, 0, 1, 2); #1;
    chk("nolu_stall", 32'(IFID_Stall), 0);
    cyc();
    id(1, 6, 5, 1, 0, 0, 0, 0); cyc();
    id(1, 5, 7, 1, 5, 3, 0, 0); #1;
    chk("addi_rt_stall", 32'(IFID_Stall), 0);
    cyc();

    // LW x0 then SW using x0 as Rt: register 0 still hazards
    id(1, 6, 0, 1, 0, 0, 0, 0); cyc();
    id(1, 7, 0, 2, 0, 8, 3, 9); #1;
    chk("x0_stall", 32'(IFID_Stall), 1);
    cyc(); cyc();
    chk("x0_sw_mw", 32'(EX_MemWrite), 1);

    // MUL x7,x10,x11 for 3 cycles
    id(1, 9, 7, 10, 11, 0, 30, 10); cyc();
    id(1, 1, 8, 1, 2, 0, 5, 6); #1;
    chk("mul1_a", EX_A, 30); chk("mul1_b", EX_B, 10);
    chk("mul1_last", 32'(EX_Last), 0); chk("mul1_stall", 32'(IFID_Stall), 1);
    cyc(); #1;
    chk("mul2_last", 32'(EX_Last), 0); chk("mul2_stall", 32'(IFID_Stall), 1);
    cyc(); #1;
    chk("mul3_last", 32'(EX_Last), 1); chk("mul3_a", EX_A, 30); chk("mul3_stall", 32'(IFID_Stall), 0);
    cyc();
    chk("mul_next_rd", 32'(EX_Rd), 8); chk("mul_next_a", EX_A, 5);

    // MUL with two downstream stall cycles: five EX cycles
    id(1, 9, 7, 10, 11, 0, 30, 10); cyc();
    id(1, 1, 9, 1, 2, 0, 5, 6); cyc();
    Stall_Ext = 1; cyc(); cyc();
    Stall_Ext = 0; #1;
    chk("muls4_last", 32'(EX_Last), 0); chk("muls4_a", EX_A, 30);
    cyc();
    chk("muls5_last", 32'(EX_Last), 1); chk("muls5_b", EX_B, 10);
    cyc();
    chk("muls_next_rd", 32'(EX_Rd), 9);

    // Flush wins over load-use
    id(1, 6, 5, 1, 0, 0, 0, 0); cyc();
    id(1, 1, 6, 5, 1, 0, 7, 8); Flush = 1; #1;
    chk("fl_lu_stall", 32'(IFID_Stall), 0);
    cyc(); Flush = 0;
    chk("fl_lu_valid", 32'(EX_Valid), 0); chk("fl_lu_mr", 32'(EX_MemRead), 0); #1;
    chk("fl_lu_after", 32'(IFID_Stall), 0);
    cyc();
    chk("fl_lu_add", 32'(EX_Rd), 6);

    // Flush wins over MULBUSY
    id(1, 9, 7, 10, 11, 0, 30, 10); cyc();
    id(1, 1, 8, 1, 2, 0, 5, 6); Flush = 1; #1;
    chk("fl_mul_stall", 32'(IFID_Stall), 0);
    cyc(); Flush = 0;
    chk("fl_mul_valid", 32'(EX_Valid), 0); #1;
    chk("fl_mul_after", 32'(IFID_Stall), 0);
    cyc();
    chk("fl_mul_next", 32'(EX_Rd), 8); chk("fl_mul_last", 32'(EX_Last), 1);

    // RST during MULBUSY
    id(1, 9, 7, 10, 11, 0, 30, 10); cyc();
    id(1, 1, 12, 3, 4, 0, 40, 2); RST = 1; cyc(); RST = 0;
    chk("rmul_valid", 32'(EX_Valid), 0); chk("rmul_a", EX_A, 0); chk("rmul_b", EX_B, 0);
    chk("rmul_rd", 32'(EX_Rd), 0); chk("rmul_op", 32'(EX_Op), 0);
    cyc();
    chk("rmul_add_v", 32'(EX_Valid), 1); chk("rmul_add_rd", 32'(EX_Rd), 12); chk("rmul_add_a", EX_A, 40);

    // invalid LW, undefined opcode, downstream hold
    id(0, 6, 5, 1, 0, 0, 0, 0); cyc();
    chk("inv_mr", 32'(EX_MemRead), 0); chk("inv_last", 32'(EX_Last), 0);
    id(1, 12, 13, 1, 0, 0, 0, 0); cyc();
    chk("op12_rw", 32'(EX_RegWrite), 0); chk("op12_last", 32'(EX_Last), 1);
    id(1, 1, 14, 1, 2, 0, 3, 4); Stall_Ext = 1; #1;
    chk("ext_stall", 32'(IFID_Stall), 1);
    cyc();
    chk("ext_hold_rd", 32'(EX_Rd), 13);
    Stall_Ext = 0; cyc();
    chk("ext_release_rd", 32'(EX_Rd), 14);

    id(0, 0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
